// File: rtl/countdown_timer.sv
// mm:ss kitchen countdown timer: set with SELECT/ADJUST, run/pause with START, BUZZ at 00:00.
// Optional: define COUNTDOWN_RELOAD_EN to restore the last started interval after the alarm.
module countdown_timer #(
  parameter int MAX_MIN   = 59,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en1hz,
  input  logic       sig2hz,
  input  logic       START,
  input  logic       SELECT,
  input  logic       ADJUST,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       MINON,
  output logic       SECON,
  output logic       RUNNING,
  output logic       BUZZ,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_SETMIN = 3'd1,
    ST_SETSEC = 3'd2,
    ST_RUN    = 3'd3,
    ST_ALARM  = 3'd4
  } state_t;

  localparam logic [6:0] MAX_MIN_L   = 7'(MAX_MIN);
  localparam logic [7:0] ALARM_SEC_L = 8'(ALARM_SEC);

  state_t     state, state_nx;
  logic [2:0] mt_nx, st_nx;
  logic [3:0] mo_nx, so_nx;
  logic [7:0] alarm_cnt, alarm_cnt_nx;
  logic [2:0] load_mt, load_st;
  logic [3:0] load_mo, load_so;
  logic [6:0] min_bin;
  logic       is_zero, is_one, any_btn;

  assign min_bin = 7'(min_tens) * 7'd10 + 7'(min_ones);
  assign is_zero = (min_tens == 3'd0) && (min_ones == 4'd0) && (sec_tens == 3'd0) && (sec_ones == 4'd0);
  assign is_one  = (min_tens == 3'd0) && (min_ones == 4'd0) && (sec_tens == 3'd0) && (sec_ones == 4'd1);
  assign any_btn = START | SELECT | ADJUST;

`ifdef COUNTDOWN_RELOAD_EN
  // Reload holds the interval of the last fresh start; paused marks a resume so it is not relatched.
  logic [2:0] rl_mt, rl_st, rl_mt_nx, rl_st_nx;
  logic [3:0] rl_mo, rl_so, rl_mo_nx, rl_so_nx;
  logic       paused, paused_nx;
  assign load_mt = rl_mt;
  assign load_mo = rl_mo;
  assign load_st = rl_st;
  assign load_so = rl_so;
`else
  assign load_mt = 3'd0;
  assign load_mo = 4'd0;
  assign load_st = 3'd0;
  assign load_so = 4'd0;
`endif

  always_comb begin
    state_nx     = state;
    mt_nx        = min_tens;
    mo_nx        = min_ones;
    st_nx        = sec_tens;
    so_nx        = sec_ones;
    alarm_cnt_nx = alarm_cnt;
`ifdef COUNTDOWN_RELOAD_EN
    rl_mt_nx  = rl_mt;
    rl_mo_nx  = rl_mo;
    rl_st_nx  = rl_st;
    rl_so_nx  = rl_so;
    paused_nx = paused;
`endif
    case (state)
      ST_STOP: begin
        if (START) begin
          if (!is_zero) begin
            state_nx = ST_RUN;
`ifdef COUNTDOWN_RELOAD_EN
            if (!paused) begin
              rl_mt_nx = min_tens;
              rl_mo_nx = min_ones;
              rl_st_nx = sec_tens;
              rl_so_nx = sec_ones;
            end
            paused_nx = 1'b0;
`endif
          end
        end else if (SELECT) begin
          state_nx = ST_SETMIN;
`ifdef COUNTDOWN_RELOAD_EN
          paused_nx = 1'b0;
`endif
        end
      end
      ST_SETMIN: begin
        if (START) begin
          state_nx = ST_STOP;
        end else if (SELECT) begin
          state_nx = ST_SETSEC;
        end else if (ADJUST) begin
          if (min_bin >= MAX_MIN_L) begin
            mt_nx = 3'd0;
            mo_nx = 4'd0;
          end else if (min_ones == 4'd9) begin
            mt_nx = min_tens + 3'd1;
            mo_nx = 4'd0;
          end else begin
            mo_nx = min_ones + 4'd1;
          end
        end
      end
      ST_SETSEC: begin
        if (START || SELECT) begin
          state_nx = ST_STOP;
        end else if (ADJUST) begin
          if (sec_ones == 4'd9) begin
            so_nx = 4'd0;
            st_nx = (sec_tens >= 3'd5) ? 3'd0 : sec_tens + 3'd1;
          end else begin
            so_nx = sec_ones + 4'd1;
          end
        end
      end
      ST_RUN: begin
        if (START) begin
          state_nx = ST_STOP;
`ifdef COUNTDOWN_RELOAD_EN
          paused_nx = 1'b1;
`endif
        end else if (en1hz) begin
          if (is_one || is_zero) begin
            state_nx     = ST_ALARM;
            alarm_cnt_nx = 8'd0;
            mt_nx = 3'd0;
            mo_nx = 4'd0;
            st_nx = 3'd0;
            so_nx = 4'd0;
          end else if (sec_ones != 4'd0) begin
            so_nx = sec_ones - 4'd1;
          end else if (sec_tens != 3'd0) begin
            st_nx = sec_tens - 3'd1;
            so_nx = 4'd9;
          end else begin
            st_nx = 3'd5;
            so_nx = 4'd9;
            if (min_ones != 4'd0) begin
              mo_nx = min_ones - 4'd1;
            end else begin
              mo_nx = 4'd9;
              mt_nx = min_tens - 3'd1;
            end
          end
        end
      end
      ST_ALARM: begin
        if (any_btn || (en1hz && (alarm_cnt + 8'd1 >= ALARM_SEC_L))) begin
          state_nx     = ST_STOP;
          alarm_cnt_nx = 8'd0;
          mt_nx = load_mt;
          mo_nx = load_mo;
          st_nx = load_st;
          so_nx = load_so;
        end else if (en1hz) begin
          alarm_cnt_nx = alarm_cnt + 8'd1;
        end
      end
      default: begin
        state_nx     = ST_STOP;
        alarm_cnt_nx = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_STOP;
      min_tens  <= 3'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 3'd0;
      sec_ones  <= 4'd0;
      alarm_cnt <= 8'd0;
    end else begin
      state     <= state_nx;
      min_tens  <= mt_nx;
      min_ones  <= mo_nx;
      sec_tens  <= st_nx;
      sec_ones  <= so_nx;
      alarm_cnt <= alarm_cnt_nx;
    end
  end

`ifdef COUNTDOWN_RELOAD_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rl_mt  <= 3'd0;
      rl_mo  <= 4'd0;
      rl_st  <= 3'd0;
      rl_so  <= 4'd0;
      paused <= 1'b0;
    end else begin
      rl_mt  <= rl_mt_nx;
      rl_mo  <= rl_mo_nx;
      rl_st  <= rl_st_nx;
      rl_so  <= rl_so_nx;
      paused <= paused_nx;
    end
  end
`endif

  always_comb begin
    MINON = 1'b1;
    SECON = 1'b1;
    if (state == ST_SETMIN) MINON = sig2hz;
    if (state == ST_SETSEC) SECON = sig2hz;
  end

  assign RUNNING   = (state == ST_RUN);
  assign BUZZ      = (state == ST_ALARM);
  assign state_dbg = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: setting, countdown/borrow, alarm, pause, wrap, async reset.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en1hz = 1'b0, sig2hz = 1'b0, start_p = 1'b0, select_p = 1'b0, adjust_p = 1'b0;
  logic [2:0] min_tens, sec_tens, state_dbg;
  logic [3:0] min_ones, sec_ones;
  logic       minon, secon, running, buzz;
  logic [15:0] disp;
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] S_STOP = 3'd0, S_SETMIN = 3'd1, S_SETSEC = 3'd2, S_RUN = 3'd3;

  countdown_timer #(.MAX_MIN(59), .ALARM_SEC(10)) dut (
    .clk(clk), .n_rst(n_rst), .en1hz(en1hz), .sig2hz(sig2hz),
    .START(start_p), .SELECT(select_p), .ADJUST(adjust_p),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .MINON(minon), .SECON(secon), .RUNNING(running), .BUZZ(buzz), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  assign disp = {1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

  task automatic pulse(input logic s, input logic sel, input logic adj, input logic en);
    @(negedge clk);
    start_p = s; select_p = sel; adjust_p = adj; en1hz = en;
    @(negedge clk);
    start_p = 1'b0; select_p = 1'b0; adjust_p = 1'b0; en1hz = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic set_time(input int m, input int s);
    pulse(0, 1, 0, 0);
    repeat (m) pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    repeat (s) pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_tests++;
    if (disp !== 16'h0000 || state_dbg !== S_STOP) begin
      n_fail++; $display("FAIL reset_state: disp=%h state=%0d want 0000/0", disp, state_dbg);
    end
    n_tests++;
    if ({minon, secon, running, buzz} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_flags: got %b want 1100", {minon, secon, running, buzz});
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_set();
    do_reset();
    pulse(0, 1, 0, 0);
    sig2hz = 1'b0; #1;
    n_tests++;
    if (state_dbg !== S_SETMIN || minon !== 1'b0 || secon !== 1'b1) begin
      n_fail++; $display("FAIL setmin_blink0: state=%0d minon=%b secon=%b want 1/0/1", state_dbg, minon, secon);
    end
    sig2hz = 1'b1; #1;
    n_tests++;
    if (minon !== 1'b1) begin
      n_fail++; $display("FAIL setmin_blink1: minon=%b want 1", minon);
    end
    repeat (3) pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    sig2hz = 1'b0; #1;
    n_tests++;
    if (state_dbg !== S_SETSEC || minon !== 1'b1 || secon !== 1'b0 || disp !== 16'h0300) begin
      n_fail++; $display("FAIL setsec_blink: state=%0d minon=%b secon=%b disp=%h want 2/1/0/0300", state_dbg, minon, secon, disp);
    end
    repeat (5) pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    n_tests++;
    if (disp !== 16'h0305 || state_dbg !== S_STOP) begin
      n_fail++; $display("FAIL set_0305: disp=%h state=%0d want 0305/0", disp, state_dbg);
    end
    pulse(0, 0, 1, 1);
    n_tests++;
    if (disp !== 16'h0305) begin
      n_fail++; $display("FAIL stop_ignores: disp=%h want 0305", disp);
    end
  endtask

  task automatic test_run();
    do_reset();
    set_time(1, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0059 || running !== 1'b1) begin
      n_fail++; $display("FAIL run_first: disp=%h running=%b want 0059/1", disp, running);
    end
    repeat (10) pulse(0, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0049) begin
      n_fail++; $display("FAIL run_ten: disp=%h want 0049", disp);
    end
    pulse(0, 1, 1, 0);
    n_tests++;
    if (disp !== 16'h0049 || state_dbg !== S_RUN) begin
      n_fail++; $display("FAIL run_ignore_btn: disp=%h state=%0d want 0049/3", disp, state_dbg);
    end
    do_reset();
    set_time(10, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0959) begin
      n_fail++; $display("FAIL borrow_tens: disp=%h want 0959", disp);
    end
  endtask

  task automatic test_alarm();
    do_reset();
    set_time(0, 2);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0001 || buzz !== 1'b0) begin
      n_fail++; $display("FAIL alarm_pre: disp=%h buzz=%b want 0001/0", disp, buzz);
    end
    pulse(0, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0000 || buzz !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL alarm_enter: disp=%h buzz=%b running=%b want 0000/1/0", disp, buzz, running);
    end
    repeat (9) pulse(0, 0, 0, 1);
    n_tests++;
    if (buzz !== 1'b1) begin
      n_fail++; $display("FAIL alarm_hold9: buzz=%b want 1", buzz);
    end
    pulse(0, 0, 0, 1);
    n_tests++;
`ifdef COUNTDOWN_RELOAD_EN
    if (buzz !== 1'b0 || state_dbg !== S_STOP || disp !== 16'h0002) begin
      n_fail++; $display("FAIL alarm_timeout: buzz=%b state=%0d disp=%h want 0/0/0002", buzz, state_dbg, disp);
    end
`else
    if (buzz !== 1'b0 || state_dbg !== S_STOP || disp !== 16'h0000) begin
      n_fail++; $display("FAIL alarm_timeout: buzz=%b state=%0d disp=%h want 0/0/0000", buzz, state_dbg, disp);
    end
`endif
  endtask

  task automatic test_reload();
    do_reset();
    set_time(0, 3);
    pulse(1, 0, 0, 0);
    repeat (3) pulse(0, 0, 0, 1);
    n_tests++;
    if (buzz !== 1'b1) begin
      n_fail++; $display("FAIL reload_alarm: buzz=%b want 1", buzz);
    end
    pulse(1, 0, 0, 0);
    n_tests++;
`ifdef COUNTDOWN_RELOAD_EN
    if (disp !== 16'h0003 || state_dbg !== S_STOP || buzz !== 1'b0) begin
      n_fail++; $display("FAIL reload_exit: disp=%h state=%0d buzz=%b want 0003/0/0", disp, state_dbg, buzz);
    end
`else
    if (disp !== 16'h0000 || state_dbg !== S_STOP || buzz !== 1'b0) begin
      n_fail++; $display("FAIL reload_exit: disp=%h state=%0d buzz=%b want 0000/0/0", disp, state_dbg, buzz);
    end
`endif
  endtask

  task automatic test_pause();
    do_reset();
    set_time(0, 30);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0030 || running !== 1'b0 || state_dbg !== S_STOP) begin
      n_fail++; $display("FAIL pause_hold: disp=%h running=%b state=%0d want 0030/0/0", disp, running, state_dbg);
    end
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_tests++;
    if (disp !== 16'h0029 || running !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume: disp=%h running=%b want 0029/1", disp, running);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pulse(0, 1, 0, 0);
    repeat (59) pulse(0, 0, 1, 0);
    n_tests++;
    if (disp !== 16'h5900) begin
      n_fail++; $display("FAIL min_max: disp=%h want 5900", disp);
    end
    pulse(0, 0, 1, 0);
    n_tests++;
    if (disp !== 16'h0000) begin
      n_fail++; $display("FAIL min_wrap: disp=%h want 0000", disp);
    end
    pulse(0, 1, 1, 0);
    n_tests++;
    if (state_dbg !== S_SETSEC || disp !== 16'h0000) begin
      n_fail++; $display("FAIL prio_sel_adj: state=%0d disp=%h want 2/0000", state_dbg, disp);
    end
    repeat (59) pulse(0, 0, 1, 0);
    n_tests++;
    if (disp !== 16'h0059) begin
      n_fail++; $display("FAIL sec_max: disp=%h want 0059", disp);
    end
    pulse(0, 0, 1, 0);
    n_tests++;
    if (disp !== 16'h0000) begin
      n_fail++; $display("FAIL sec_wrap: disp=%h want 0000", disp);
    end
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    n_tests++;
    if (state_dbg !== S_STOP || running !== 1'b0) begin
      n_fail++; $display("FAIL start_zero: state=%0d running=%b want 0/0", state_dbg, running);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_time(2, 15);
    pulse(1, 0, 0, 0);
    n_tests++;
    if (disp !== 16'h0215 || running !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: disp=%h running=%b want 0215/1", disp, running);
    end
    #2 n_rst = 1'b0;
    #1;
    n_tests++;
    if (disp !== 16'h0000 || running !== 1'b0 || state_dbg !== S_STOP) begin
      n_fail++; $display("FAIL arst_run: disp=%h running=%b state=%0d want 0000/0/0", disp, running, state_dbg);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    set_time(0, 1);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_tests++;
    if (buzz !== 1'b1) begin
      n_fail++; $display("FAIL arst_alarm_pre: buzz=%b want 1", buzz);
    end
    #2 n_rst = 1'b0;
    #1;
    n_tests++;
    if (buzz !== 1'b0 || state_dbg !== S_STOP) begin
      n_fail++; $display("FAIL arst_alarm: buzz=%b state=%0d want 0/0", buzz, state_dbg);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_set();
    test_run();
    test_alarm();
    test_reload();
    test_pause();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
